// File: rtl/key_store_if.sv
// Key store port bundle: router write strobe, encryption-block read request
// and the served key byte with its status flags.
interface key_store_if #(
    parameter int MAX_KEY_LEN = 16,
    parameter int LW          = $clog2(MAX_KEY_LEN + 1)
);
    logic [7:0]    key_byte;
    logic          key_byte_pulse;
    logic          key_req;
    logic [7:0]    key_out;
    logic          key_valid;
    logic          key_ready;
    logic [LW-1:0] key_len;
    logic          key_overflow;

    // Router / encryption-block side.
    modport master (
        output key_byte, key_byte_pulse, key_req,
        input  key_out, key_valid, key_ready, key_len, key_overflow
    );

    // Key store side.
    modport slave (
        input  key_byte, key_byte_pulse, key_req,
        output key_out, key_valid, key_ready, key_len, key_overflow
    );
endinterface

// File: rtl/key_store.sv
// Stream-cipher key store: loads key bytes and replays them cyclically, one per request.
// Optional KEY_STORE_AUTOCLEAR_EN: a write after serving has begun starts a new key.
module key_store #(
    parameter int MAX_KEY_LEN = 16,
    parameter int LW          = $clog2(MAX_KEY_LEN + 1)
) (
    input  logic        clk,
    input  logic        nrst,
    key_store_if.slave  bus
);
    localparam int            AW      = $clog2(MAX_KEY_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_KEY_LEN);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);

`ifdef KEY_STORE_AUTOCLEAR_EN
    typedef enum logic {
        PH_LOAD  = 1'b0,
        PH_SERVE = 1'b1
    } phase_e;

    phase_e phase_q, phase_d;
`endif

    logic [7:0]    mem_q [MAX_KEY_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    key_out_q, key_out_d;
    logic          key_valid_q, key_valid_d;
    logic          overflow_q, overflow_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_hit;
    logic          new_key;

    assign rd_hit = bus.key_req && (len_q != '0);

`ifdef KEY_STORE_AUTOCLEAR_EN
    assign new_key = bus.key_byte_pulse && (phase_q == PH_SERVE);
`else
    assign new_key = 1'b0;
`endif

    // Read is evaluated first from pre-write state; the write then overrides
    // pointer, length and phase where both touch them.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        len_d       = len_q;
        rd_ptr_d    = rd_ptr_q;
        key_out_d   = key_out_q;
        key_valid_d = 1'b0;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = bus.key_byte;
`ifdef KEY_STORE_AUTOCLEAR_EN
        phase_d     = phase_q;
`endif

        if (rd_hit) begin
            key_out_d   = mem_q[rd_ptr_q[AW-1:0]];
            key_valid_d = 1'b1;
            rd_ptr_d    = (rd_ptr_q + LEN_ONE == len_q) ? '0 : rd_ptr_q + LEN_ONE;
`ifdef KEY_STORE_AUTOCLEAR_EN
            phase_d     = PH_SERVE;
`endif
        end

        if (bus.key_byte_pulse) begin
            if (new_key) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                len_d      = LEN_ONE;
                rd_ptr_d   = '0;
                overflow_d = 1'b0;
`ifdef KEY_STORE_AUTOCLEAR_EN
                phase_d    = PH_LOAD;
`endif
            end else if (len_q != LEN_MAX) begin
                wr_en   = 1'b1;
                wr_addr = len_q[AW-1:0];
                len_d   = len_q + LEN_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            // NOTE: the key memory is reset too, so a freshly reset store never replays stale key material.
            for (int i = 0; i < MAX_KEY_LEN; i++) begin
                mem_q[i] <= '0;
            end
            len_q       <= '0;
            rd_ptr_q    <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef KEY_STORE_AUTOCLEAR_EN
            phase_q     <= PH_LOAD;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
`ifdef KEY_STORE_AUTOCLEAR_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign bus.key_out      = key_out_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.key_ready    = (len_q != '0);
    assign bus.key_len      = len_q;
    assign bus.key_overflow = overflow_q;

endmodule

// File: tb/tb_key_store.sv
// Scoreboard bench for key_store: queue-based key model, directed test-plan
// sequences followed by randomized writes, reads and resets.
module tb_key_store;
    localparam int MAX = 16;
    localparam int LW  = $clog2(MAX + 1);

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    key_store_if #(.MAX_KEY_LEN(MAX)) bus ();

    key_store #(.MAX_KEY_LEN(MAX)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       exp_q[$];
    logic [7:0] exp_out = 8'h00;

    // Reference model: the key as a queue of bytes plus a replay index.
    logic [7:0] key_m[$];
    int         rd_m       = 0;
    bit         consumed_m = 1'b0;
    bit         ovf_m      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        key_m.delete();
        rd_m       = 0;
        consumed_m = 1'b0;
        ovf_m      = 1'b0;
        exp_q.delete();
        exp_out    = 8'h00;
    endtask

    task automatic model_step(input bit pulse, input logic [7:0] b, input bit req);
`ifdef KEY_STORE_AUTOCLEAR_EN
        bit was_consumed;
        was_consumed = consumed_m;
`endif
        if (req && key_m.size() > 0) begin
            exp_q.push_back('{key_m[rd_m], cyc + 1});
            rd_m       = (rd_m + 1) % key_m.size();
            consumed_m = 1'b1;
        end
        if (pulse) begin
`ifdef KEY_STORE_AUTOCLEAR_EN
            if (was_consumed) begin
                key_m.delete();
                key_m.push_back(b);
                rd_m       = 0;
                consumed_m = 1'b0;
                ovf_m      = 1'b0;
            end else
`endif
            if (key_m.size() < MAX) key_m.push_back(b);
            else                    ovf_m = 1'b1;
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks status after the next edge.
    task automatic drive(input bit pulse, input logic [7:0] b, input bit req);
        bus.key_byte_pulse = pulse;
        bus.key_byte       = b;
        bus.key_req        = req;
        model_step(pulse, b, req);
        @(posedge clk);
        #1;
        bus.key_byte_pulse = 1'b0;
        bus.key_req        = 1'b0;
        check("key_len", 32'(bus.key_len), key_m.size());
        check("key_ready", 32'(bus.key_ready), 32'(key_m.size() > 0));
        check("key_overflow", 32'(bus.key_overflow), 32'(ovf_m));
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic apply_reset();
        nrst = 1'b1;
        model_reset();
        #1;
        check("rst_key_valid", 32'(bus.key_valid), 0);
        check("rst_key_out", 32'(bus.key_out), 0);
        check("rst_key_ready", 32'(bus.key_ready), 0);
        check("rst_key_len", 32'(bus.key_len), 0);
        check("rst_key_overflow", 32'(bus.key_overflow), 0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
    endtask

    // Monitor: compares every cycle's key_valid/key_out against the scoreboard.
    always @(negedge clk) begin
        bit exp_v;
        if (!nrst) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("key_valid", 32'(bus.key_valid), 32'(exp_v));
            if (exp_v) begin
                exp_out = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("key_out", 32'(bus.key_out), 32'(exp_out));
        end
    end

    initial begin
        nrst               = 1'b1;
        bus.key_byte       = 8'h00;
        bus.key_byte_pulse = 1'b0;
        bus.key_req        = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // Request with nothing loaded must be ignored.
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // Three-byte key replayed with wrap-around.
        drive(1'b1, 8'hA1, 1'b0);
        drive(1'b1, 8'hB2, 1'b0);
        drive(1'b1, 8'hC3, 1'b0);
        repeat (5) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // Seventeen writes into a sixteen-byte store, then a full replay.
        apply_reset();
        for (int i = 0; i < 17; i++) drive(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // Write after serving began.
        apply_reset();
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h55, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // Simultaneous write and read.
        apply_reset();
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h77, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // Reset lands while a served byte is in flight.
        apply_reset();
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        apply_reset();
        drive(1'b0, 8'h00, 1'b0);

        // Randomized traffic: a write-heavy phase that reaches overflow, then a mixed phase.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 2) == 0, 8'($urandom), ($urandom % 16) == 0);
        end
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 250) == 0) apply_reset();
            drive(($urandom % 4) == 0, 8'($urandom), ($urandom % 2) == 0);
        end

        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("pending_expected", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_store.md
# key_store

- Holds the stream-cipher key and replays it one byte per request.
- Sits between the data router and the encryption block:
  - it consumes the router's `key_byte` / `key_byte_pulse` pair;
  - it serves key bytes to the encryption block in cyclic order, wrapping at the loaded key length.
- Tracks the loaded key length and flags overflow.
- Starts a new key automatically when key bytes arrive after encryption has begun consuming the current key.

## Interface

Parameters:
- `MAX_KEY_LEN`, default 16: key byte capacity; must be ≥ 2.
- `LW`, default `$clog2(MAX_KEY_LEN+1)`: width of the length count. Derived; not to be overridden.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous, active-high reset. Asserting it (1) clears all state immediately.
- `key_byte`  in  8  key byte from the data router; sampled only when `key_byte_pulse`=1.
- `key_byte_pulse`  in  1  one-cycle write strobe.
- `key_req`  in  1  one-cycle request for the next key byte, from the encryption block.
- `key_out`  out  8  served key byte; registered and held between serves.
- `key_valid`  out  1  one-cycle pulse; `key_out` is new this cycle.
- `key_ready`  out  1  high when `key_len` > 0.
- `key_len`  out  LW  number of key bytes loaded, 0..`MAX_KEY_LEN`.
- `key_overflow`  out  1  sticky; a write was dropped because the store was full.

## Operation

State:
- `mem[MAX_KEY_LEN]` × 8 bits.
- `len` (drives `key_len`).
- `rd_ptr`, range 0..`len`-1.
- Phase flag `consumed`: 0 = LOAD, 1 = SERVE.

Reset values:
- `mem`, `len`, `rd_ptr`, `consumed`: all 0.
- Outputs: `key_out`=0, `key_valid`=0, `key_ready`=0, `key_overflow`=0.

Write (`key_byte_pulse`=1):
- LOAD phase, `len` < `MAX_KEY_LEN`: `mem[len]`←`key_byte`, `len`←`len`+1.
- LOAD phase, `len` = `MAX_KEY_LEN`: byte dropped, `key_overflow`←1; nothing else changes.
- SERVE phase (new-key start, see Configuration):
  - `mem[0]`←`key_byte`, `len`←1, `rd_ptr`←0, `consumed`←0.
  - `key_overflow`←0.

Read (`key_req`=1):
- `len` = 0: request ignored. `key_valid` stays 0, `key_out` holds.
- `len` > 0, on the next edge:
  - `key_out`←`mem[rd_ptr]`, `key_valid`←1, `consumed`←1.
  - `rd_ptr`←(`rd_ptr`+1 = `len`) ? 0 : `rd_ptr`+1.

Simultaneous `key_byte_pulse` and `key_req` in one cycle:
- The read is served from pre-write state: old `mem[rd_ptr]`, `key_valid`=1.
- The write is then applied, and its effects take priority:
  - a new-key start forces `rd_ptr`=0, `len`=1 and `consumed`=0, overriding the read's pointer advance and its `consumed`←1;
  - an append in LOAD phase also sets `consumed`=1, because the read consumed the key.

Other rules:
- Writes landing at the same time as a read never change the byte returned by that read.
- Writes never modify `key_out`.

## Timing

- Read latency: `key_req` at edge N produces `key_out` / `key_valid` valid after edge N+1. `key_valid` is high for exactly one cycle.
- Back-to-back `key_req` every cycle is supported: one byte per cycle, with wrap-around.
- Write latency:
  - `key_len` and `key_ready` update after the same edge that samples `key_byte_pulse`;
  - a byte written at edge N can be read by a `key_req` sampled at edge N+1.
- Reset mid-operation: outputs return to reset values asynchronously. Any in-flight `key_valid` is squashed.
- No combinational path from any input to any output.

## Configuration

- Macro `KEY_STORE_AUTOCLEAR_EN`.
- Defined: the SERVE-phase new-key start behaves as in Operation.
- Undefined:
  - `consumed` is not implemented;
  - writes always append, or set overflow when full;
  - the only way to load a different key is to assert `nrst`;
  - read behaviour is unchanged.

## Test plan

- Reset, then `key_req` with no key loaded → `key_valid` stays 0, `key_out`=0x00, `key_ready`=0.
- Write 0xA1, 0xB2, 0xC3, then 5 back-to-back `key_req` → `key_out` sequence A1, B2, C3, A1, B2, one cycle after each request; `key_len`=3.
- Write 17 bytes 0x00..0x10 with `MAX_KEY_LEN`=16 → `key_len`=16, `key_overflow`=1, and 16 reads return 0x00..0x0F.
- Load 0x11, 0x22, read once (returns 0x11), then write 0x55 → with `KEY_STORE_AUTOCLEAR_EN`:
  - `key_len`=1 and the next reads return 55, 55;
  - without the macro: `key_len`=3 and reads return 22, 55, 11.
- Load 0x11, 0x22, read once, then in one cycle pulse write 0x77 and `key_req` → that read returns 0x22. With `KEY_STORE_AUTOCLEAR_EN`:
  - `key_len`=1;
  - the following read returns 0x77.
- Assert `nrst` in the cycle between `key_req` and the expected `key_valid` → no `key_valid` pulse, `key_len`=0, `key_out`=0x00.
